// File: rtl/edge_trap_array.sv
// edge_trap_array: per-channel synchronised edge trap with sticky flags, saturating counters and aggregate flag
module edge_trap_array #(
   parameter int N_CH        = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         in,
   input  logic [2*N_CH-1:0]       mode,
   input  logic [N_CH-1:0]         clr,
   output logic [N_CH-1:0]         out,
   output logic                    any_out,
   output logic [N_CH*CNT_W-1:0]   count,
   output logic [N_CH-1:0]         overflow
);
   logic [N_CH-1:0] s, last_q, ev, out_q, out_d, ovf_q, ovf_d;
   logic [N_CH*CNT_W-1:0] cnt_q, cnt_d;
   logic any_q;
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = in;
      end else begin : g_sync
         logic [N_CH-1:0] sync_q [SYNC_STAGES];
         always_ff @(posedge clk)
            if (!reset) sync_q <= '{default: '0};
            else begin
               sync_q[0] <= in;
               for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
         assign s = sync_q[SYNC_STAGES-1];
      end
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic [CNT_W-1:0] c;
         logic sat;
         assign c   = cnt_q[i*CNT_W +: CNT_W];
         assign sat = &c;
         // mode bit 0 enables rising, bit 1 enables falling
         assign ev[i]    = (mode[2*i] & s[i] & ~last_q[i]) | (mode[2*i+1] & ~s[i] & last_q[i]);
         assign out_d[i] = ev[i] | (out_q[i] & ~clr[i]);
         assign cnt_d[i*CNT_W +: CNT_W] = clr[i] ? CNT_W'(ev[i]) :
                                          (ev[i] && !sat) ? c + CNT_W'(1) : c;
         assign ovf_d[i] = ~clr[i] & (ovf_q[i] | (ev[i] & sat));
      end
   endgenerate
   always_ff @(posedge clk)
      if (!reset) begin
         last_q <= '0;
         out_q  <= '0;
         ovf_q  <= '0;
         cnt_q  <= '0;
         any_q  <= 1'b0;
      end else begin
         last_q <= s;
         out_q  <= out_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
         any_q  <= |out_q;
      end
   assign out      = out_q;
   assign any_out  = any_q;
   assign count    = cnt_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_edge_trap_array.sv
// tb_edge_trap_array: randomized bench against a cycle-level behavioural model of the edge trap
module tb_edge_trap_array;
   localparam int N = 8;
   localparam int S = 2;
   localparam int W = 4;
   localparam int MAXC = (1 << W) - 1;
   logic clk = 1'b0;
   logic reset;
   logic [N-1:0] in, clr, out, overflow;
   logic [2*N-1:0] mode;
   logic any_out;
   logic [N*W-1:0] count;
   int n_tests = 0;
   int n_fail = 0;
   logic [N-1:0] q_m[$];
   logic [N-1:0] last_m, out_m, ovf_m;
   logic any_m;
   int cnt_m[N];
   always #5 clk = ~clk;
   edge_trap_array #(.N_CH(N), .SYNC_STAGES(S), .CNT_W(W)) dut (
      .clk(clk), .reset(reset), .in(in), .mode(mode), .clr(clr),
      .out(out), .any_out(any_out), .count(count), .overflow(overflow)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [N*W-1:0] cnt_vec();
      logic [N*W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*W +: W] = W'(cnt_m[i]);
      return v;
   endfunction
   // s is the input as seen S edges ago; reset flushes that history to zero
   task automatic model_edge();
      logic [N-1:0] s;
      logic rise, fall, ev;
      int m;
      if (!reset) begin
         q_m = {};
         repeat (S + 1) q_m.push_back('0);
         last_m = '0;
         out_m = '0;
         ovf_m = '0;
         any_m = 1'b0;
         for (int i = 0; i < N; i++) cnt_m[i] = 0;
      end else begin
         q_m.push_front(in);
         s = q_m[S];
         void'(q_m.pop_back());
         any_m = |out_m;
         for (int i = 0; i < N; i++) begin
            rise = s[i] && !last_m[i];
            fall = !s[i] && last_m[i];
            m = int'(mode[2*i +: 2]);
            ev = (m == 1 && rise) || (m == 2 && fall) || (m == 3 && (rise || fall));
            if (clr[i]) begin
               cnt_m[i] = ev ? 1 : 0;
               ovf_m[i] = 1'b0;
            end else if (ev) begin
               if (cnt_m[i] == MAXC) ovf_m[i] = 1'b1;
               else cnt_m[i]++;
            end
            out_m[i] = ev ? 1'b1 : (clr[i] ? 1'b0 : out_m[i]);
         end
         last_m = s;
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("out", 64'(out), 64'(out_m));
      chk("any_out", 64'(any_out), 64'(any_m));
      chk("count", 64'(count), 64'(cnt_vec()));
      chk("overflow", 64'(overflow), 64'(ovf_m));
   endtask
   initial begin
      reset = 1'b0;
      in = '1;
      mode = {N{2'b01}};
      clr = '0;
      @(negedge clk);
      repeat (3) cyc();
      reset = 1'b1;
      repeat (6) cyc();
      reset = 1'b0;
      mode = '0;
      cyc();
      reset = 1'b1;
      repeat (6) cyc();
      in = '0;
      mode = {N{2'b01}};
      repeat (4) cyc();
      for (int t = 0; t < 500; t++) begin
         in = in ^ N'($urandom & $urandom);
         clr = N'($urandom & $urandom & $urandom);
         if ($urandom_range(15) == 0) mode = 2*N'($urandom);
         reset = ($urandom_range(99) != 0);
         cyc();
      end
      reset = 1'b1;
      clr = '1;
      mode = {N{2'b11}};
      cyc();
      clr = '0;
      for (int t = 0; t < 120; t++) begin
         in = in ^ N'($urandom);
         cyc();
      end
      clr = 8'h5A;
      cyc();
      clr = '0;
      for (int t = 0; t < 200; t++) begin
         in = in ^ N'($urandom & $urandom);
         if ($urandom_range(7) == 0) mode = 2*N'($urandom);
         clr = ($urandom_range(9) == 0) ? N'($urandom) : '0;
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/edge_trap_array.md
Name: edge_trap_array

Overview:
- Multi-channel, parametrised edge trap.
- Each channel detects a programmable edge type on an asynchronous or slow input and latches it into a sticky flag. The flag holds until software or the FSM clears it.
- Each channel also keeps a saturating count of trapped edges, and an aggregate flag reports any pending event.
- Sits between raw inputs (push-buttons, done strobes from other clock-agnostic sources) and the control FSMs of the decryption datapath.

Parameters:
- N_CH, 8, number of independent channels (1..32).
- SYNC_STAGES, 2, input synchroniser flops per channel (0..3; 0 = input already synchronous).
- CNT_W, 4, width of each per-channel edge counter (1..16).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- in  input  N_CH  raw channel inputs.
- mode  input  2*N_CH  per-channel edge select; bits [2i+1:2i] for channel i: 00 disabled, 01 rising, 10 falling, 11 both.
- clr  input  N_CH  per-channel clear, level-sampled each cycle.
- out  output  N_CH  sticky trapped-edge flags.
- any_out  output  1  registered OR of all flags.
- count  output  N_CH*CNT_W  per-channel edge counters; bits [CNT_W*(i+1)-1:CNT_W*i] for channel i.
- overflow  output  N_CH  sticky counter-saturation flags.

Behaviour:
- Reset: when reset=0 at posedge, all synchroniser flops, last-value regs, out, any_out, count and overflow go to 0.
- Synchroniser:
  - in[i] passes through SYNC_STAGES flops to give s[i].
  - With SYNC_STAGES=0, s[i]=in[i] directly.
- Edge detect:
  - last[i] <= s[i] every cycle, regardless of mode.
  - rise = s & ~last; fall = ~s & last.
  - ev[i] = (mode 01 & rise) | (mode 10 & fall) | (mode 11 & (rise|fall)); mode 00 gives ev=0.
- Mode timing: mode is combinational into ev, so a change takes effect for the next detection evaluation. No spurious event is generated by a mode change alone.
- Post-reset: last=0, so an input held high through reset release yields one rising event (rising/both modes) once the value reaches s.
- Latency: an input transition first sampled at posedge k produces out=1 after posedge k+SYNC_STAGES (SYNC_STAGES=0 gives visible after posedge k).
- Flag update, per cycle: out[i] <= ev[i] ? 1 : (clr[i] ? 0 : out[i]).
  - Event beats clear on the same cycle, so no event is lost.
  - Disabled channels keep their existing flag until cleared.
- Counter update:
  - If clr[i]: count <= ev ? 1 : 0.
  - Else if ev: if count == 2^CNT_W-1, count holds and overflow <= 1; otherwise count <= count+1.
  - Counter never wraps.
- Overflow: set only as above; cleared by clr[i] unless saturation occurs the same cycle, which is impossible after clear, so clear always wins for overflow.
- any_out: registered, equals OR of the out vector of the previous cycle. It lags out by exactly one cycle; reset value 0.
- Channel independence: channels are fully independent; simultaneous events on all channels are all trapped in the same cycle.
- Reset mid-operation: reset overrides every other input; in-flight synchroniser contents are discarded.
- Glitch handling: a pulse shorter than one clock may be missed. A one-cycle high pulse on s gives rise then fall on consecutive cycles, so mode 11 counts 2.

Test Plan:
- Reset release with in=0, N_CH=8, SYNC_STAGES=2, mode=all 01: pulse in[3] high for 3 cycles at cycle 10 -> out=8'h08 after posedge 12, any_out=1 at posedge 13, count[3]=1, other counts 0.
- Channel 0 in mode 10: in[0] rises at cycle 5 and falls at cycle 9 -> no event on the rise; out[0]=1 after posedge 11.
- Channel 1 in mode 11 with CNT_W=2: toggle in[1] every 4 cycles for 5 toggles -> count[1] saturates at 3 and overflow[1]=1 after the 4th edge; 5th edge keeps 3; then clr[1] for 1 cycle -> count[1]=0, overflow[1]=0, out[1]=0.
- Simultaneous clr[2] and ev[2] in the same cycle (rising mode, flag already 1, count 5) -> out[2] stays 1, count[2]=1, overflow[2]=0.
- in all 1s held through reset, mode all 01, reset deasserted at cycle 4 -> out=8'hFF after posedge 4+SYNC_STAGES, each count=1. Repeat with mode all 00 -> out stays 0.
- Assert reset=0 for one cycle while out=8'hA5 and sync chains hold in-flight edges -> all outputs 0 next cycle; pending edges discarded unless the input level still differs from last.
